// File: rtl/cpu_mem_if.sv
// Memory bus between cpu_core (master) and its instruction/data memory (slave).
// req/we/addr/wdata/rdata/ack carry the core's o_mem_* / i_mem_* signals.
interface cpu_mem_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;

  modport master (output req, we, addr, wdata, input rdata, ack);
  modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/cpu_core.sv
// Accumulator CPU core: fetch/decode/memory FSM over a req/ack memory bus.
// Define CPU_CORE_STA_EN to implement STA; otherwise opcode 0100 runs as NOP.
//
// state    | meaning
// S_FETCH  | request instruction at PC, load IR and bump PC on ack
// S_DECODE | execute register/jump ops, dispatch memory ops or halt
// S_MEM    | data access at operand address for LDA/ADD/SUB/STA
// S_HALT   | idle until reset
module cpu_core #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  cpu_mem_if.master         mem,
  output logic [DATA_W-1:0] o_out,
  output logic              o_out_valid,
  output logic              o_halted,
  output logic [ADDR_W-1:0] o_pc
);
  localparam logic [3:0] OP_LDA = 4'h1, OP_ADD = 4'h2, OP_SUB = 4'h3, OP_STA = 4'h4,
                         OP_LDI = 4'h5, OP_JMP = 4'h6, OP_JC  = 4'h7, OP_JZ  = 4'h8,
                         OP_JNZ = 4'h9, OP_OUT = 4'hE, OP_HLT = 4'hF;

  typedef enum logic [1:0] {S_FETCH, S_DECODE, S_MEM, S_HALT} state_t;

  state_t            state, state_nxt;
  logic [DATA_W-1:0] a_q, ir_q;
  logic [ADDR_W-1:0] pc_q;
  logic              c_q, z_q;
  logic              req_q, req_nxt;

  logic [3:0]        opcode;
  logic [ADDR_W-1:0] operand;
  logic [DATA_W-1:0] imm;
  logic [DATA_W:0]   sum;
  logic [DATA_W-1:0] diff;
  logic              done, is_sta, needs_mem;

  assign opcode  = ir_q[DATA_W-1 -: 4];
  assign operand = ir_q[ADDR_W-1:0];
  assign imm     = {4'b0000, ir_q[DATA_W-5:0]};
  assign sum     = {1'b0, a_q} + {1'b0, mem.rdata};
  assign diff    = a_q - mem.rdata;
  assign done    = req_q & mem.ack;

`ifdef CPU_CORE_STA_EN
  assign is_sta  = (opcode == OP_STA);
  assign mem.we  = (state == S_MEM) && is_sta;
`else
  assign is_sta  = 1'b0;
  assign mem.we  = 1'b0;
`endif

  assign needs_mem = (opcode == OP_LDA) || (opcode == OP_ADD) || (opcode == OP_SUB) || is_sta;

  // req is registered so reset clears it at once and the first fetch starts one edge after release
  assign mem.req   = req_q;
  assign mem.addr  = (state == S_MEM) ? operand : pc_q;
  assign mem.wdata = a_q;
  assign o_halted  = (state == S_HALT);
  assign o_pc      = pc_q;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state <= S_FETCH;
      req_q <= 1'b0;
    end else begin
      state <= state_nxt;
      req_q <= req_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_nxt   = req_q;
    case (state)
      S_FETCH: begin
        if (done) begin
          state_nxt = S_DECODE;
          req_nxt   = 1'b0;
        end else begin
          req_nxt   = 1'b1;
        end
      end
      S_DECODE: begin
        if (opcode == OP_HLT) begin
          state_nxt = S_HALT;
          req_nxt   = 1'b0;
        end else if (needs_mem) begin
          state_nxt = S_MEM;
          req_nxt   = 1'b1;
        end else begin
          state_nxt = S_FETCH;
          req_nxt   = 1'b1;
        end
      end
      S_MEM: begin
        req_nxt = 1'b1;
        if (done) state_nxt = S_FETCH;
      end
      S_HALT:  req_nxt = 1'b0;
      default: begin
        state_nxt = S_FETCH;
        req_nxt   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      a_q         <= '0;
      ir_q        <= '0;
      pc_q        <= '0;
      c_q         <= 1'b0;
      z_q         <= 1'b0;
      o_out       <= '0;
      o_out_valid <= 1'b0;
    end else begin
      o_out_valid <= 1'b0;
      case (state)
        S_FETCH: begin
          if (done) begin
            ir_q <= mem.rdata;
            pc_q <= pc_q + 1'b1;
          end
        end
        S_DECODE: begin
          case (opcode)
            OP_LDI: a_q <= imm;
            OP_JMP: pc_q <= operand;
            OP_JC:  if (c_q)  pc_q <= operand;
            OP_JZ:  if (z_q)  pc_q <= operand;
            OP_JNZ: if (!z_q) pc_q <= operand;
            OP_OUT: begin
              o_out       <= a_q;
              o_out_valid <= 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (done) begin
            case (opcode)
              OP_LDA: a_q <= mem.rdata;
              OP_ADD: begin
                a_q <= sum[DATA_W-1:0];
                c_q <= sum[DATA_W];
                z_q <= (sum[DATA_W-1:0] == '0);
              end
              OP_SUB: begin
                a_q <= diff;
                c_q <= (a_q >= mem.rdata);
                z_q <= (diff == '0);
              end
              default: ;
            endcase
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: directed programs checked against an instruction-level model,
// plus hand-computed cycle counts and results.
module tb_cpu_core;
  localparam int DW = 8;
  localparam int AW = 4;

  logic          i_clk = 1'b0;
  logic          i_rst = 1'b1;
  logic [DW-1:0] o_out;
  logic          o_out_valid, o_halted;
  logic [AW-1:0] o_pc;

  cpu_mem_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  cpu_core #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .mem         (bus),
    .o_out       (o_out),
    .o_out_valid (o_out_valid),
    .o_halted    (o_halted),
    .o_pc        (o_pc)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] wdata;
  } acc_t;

  acc_t          exp_acc[$];
  logic [DW-1:0] exp_out[$];
  acc_t          t_acc;
  logic [DW-1:0] t_out;
  logic [DW-1:0] tmem [16];
  logic [DW-1:0] mmem [16];
  int            wait_tab [32];
  int            acc_idx, cnt;
  logic [DW-1:0] m_a;
  logic [AW-1:0] m_pc;
  bit            m_c, m_z;
  int            n_cmp, n_bad;
  bit            chk_en;
  int            n_valid, n_we, n_fetch0, cyc;
  logic [DW-1:0] last_out, first_out;
  bit            p_pend, p_we;
  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_wdata;
  bit            sta_en;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_acc(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] d);
    acc_t t;
    t.addr = a; t.we = w; t.wdata = d;
    exp_acc.push_back(t);
  endtask

  // Architectural model: executes the program from a copy of memory and
  // records every memory access and OUT value the core must produce.
  task automatic run_model();
    logic [DW-1:0] ir;
    logic [3:0]    op;
    logic [AW-1:0] opd;
    int            s;
    m_a = '0; m_pc = '0; m_c = 1'b0; m_z = 1'b0;
    for (int i = 0; i < 16; i++) mmem[i] = tmem[i];
    for (int k = 0; k < 64; k++) begin
      push_acc(m_pc, 1'b0, m_a);
      ir   = mmem[m_pc];
      m_pc = m_pc + 4'd1;
      op   = ir[7:4];
      opd  = ir[3:0];
      if (op == 4'hF) break;
      case (op)
        4'h1: begin push_acc(opd, 1'b0, m_a); m_a = mmem[opd]; end
        4'h2: begin
          push_acc(opd, 1'b0, m_a);
          s = int'(m_a) + int'(mmem[opd]);
          m_c = (s > 255);
          m_a = 8'(s);
          m_z = (m_a == 0);
        end
        4'h3: begin
          push_acc(opd, 1'b0, m_a);
          m_c = (m_a >= mmem[opd]);
          m_a = m_a - mmem[opd];
          m_z = (m_a == 0);
        end
        4'h4: if (sta_en) begin push_acc(opd, 1'b1, m_a); mmem[opd] = m_a; end
        4'h5: m_a = {4'h0, opd};
        4'h6: m_pc = opd;
        4'h7: if (m_c)  m_pc = opd;
        4'h8: if (m_z)  m_pc = opd;
        4'h9: if (!m_z) m_pc = opd;
        4'hE: exp_out.push_back(m_a);
        default: ;
      endcase
    end
  endtask

  // Memory responder: acks after wait_tab[access] idle request cycles.
  initial begin
    bus.ack   = 1'b0;
    bus.rdata = '0;
  end
  always @(posedge i_clk) begin
    #1;
    if (bus.ack) begin
      acc_idx++;
      cnt = 0;
    end
    bus.ack = 1'b0;
    if (bus.req) begin
      if (cnt >= wait_tab[acc_idx % 32]) begin
        bus.ack   = 1'b1;
        bus.rdata = tmem[bus.addr];
        if (bus.we) tmem[bus.addr] = bus.wdata;
      end else begin
        cnt++;
      end
    end
  end

  // Compare process
  always @(negedge i_clk) begin
    if (chk_en) begin
      if (bus.req && p_pend) begin
        check("hold_addr", bus.addr, p_addr);
        check("hold_we", bus.we, p_we);
        check("hold_wdata", bus.wdata, p_wdata);
      end
      if (bus.req && bus.ack) begin
        if (bus.addr == 0 && !bus.we) n_fetch0++;
        if (exp_acc.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_access: addr %0h, no access expected", bus.addr);
        end else begin
          t_acc = exp_acc.pop_front();
          check("acc_addr", bus.addr, t_acc.addr);
          check("acc_we", bus.we, t_acc.we);
          check("acc_wdata", bus.wdata, t_acc.wdata);
        end
      end
      if (o_out_valid) begin
        if (n_valid == 0) first_out = o_out;
        n_valid++;
        last_out = o_out;
        if (exp_out.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_out: value %0h, no output expected", o_out);
        end else begin
          t_out = exp_out.pop_front();
          check("out_value", o_out, t_out);
        end
      end
      if (bus.we) n_we++;
      if (o_halted) check("halt_req_low", bus.req, 1'b0);
    end
    p_pend  = bus.req && !bus.ack;
    p_addr  = bus.addr;
    p_we    = bus.we;
    p_wdata = bus.wdata;
  end

  task automatic clear_prog();
    for (int i = 0; i < 16; i++) tmem[i] = '0;
    for (int i = 0; i < 32; i++) wait_tab[i] = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, bus.req, 1'b0);
    check({tag, "_we"}, bus.we, 1'b0);
    check({tag, "_addr"}, bus.addr, 0);
    check({tag, "_wdata"}, bus.wdata, 0);
    check({tag, "_out"}, o_out, 0);
    check({tag, "_valid"}, o_out_valid, 1'b0);
    check({tag, "_halted"}, o_halted, 1'b0);
    check({tag, "_pc"}, o_pc, 0);
  endtask

  task automatic run_prog(input int budget, output int ncyc);
    chk_en = 1'b0;
    i_rst  = 1'b0;
    exp_acc.delete();
    exp_out.delete();
    acc_idx = 0; cnt = 0; n_valid = 0; n_we = 0; n_fetch0 = 0;
    last_out = '0; first_out = '0;
    run_model();
    @(negedge i_clk);
    i_rst  = 1'b1;
    chk_en = 1'b1;
    ncyc = 0;
    while (!o_halted && ncyc < budget) begin
      @(posedge i_clk);
      #2;
      ncyc++;
    end
    if (!o_halted) begin
      n_cmp++; n_bad++;
      $display("FAIL halt_timeout: not halted after %0d cycles", ncyc);
    end
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    #1;
    check("end_pc", o_pc, m_pc);
    check("end_a", bus.wdata, m_a);
    check("acc_left", exp_acc.size(), 0);
    check("out_left", exp_out.size(), 0);
    for (int i = 0; i < 16; i++) check("end_mem", tmem[i], mmem[i]);
  endtask

  initial begin
`ifdef CPU_CORE_STA_EN
    sta_en = 1'b1;
`else
    sta_en = 1'b0;
`endif
    n_cmp = 0; n_bad = 0; chk_en = 1'b0;
    clear_prog();
    #3 i_rst = 1'b0;
    #9;
    check_reset_outputs("reset");

    // LDI 3; OUT; HLT
    clear_prog();
    tmem[0] = 8'h53; tmem[1] = 8'hE0; tmem[2] = 8'hF0;
    run_prog(50, cyc);
    check("t1_halt_cycle", cyc, 7);
    check("t1_out", last_out, 8'd3);
    check("t1_pulses", n_valid, 1);

    // ADD with carry, SUB to zero, flag-driven jumps
    clear_prog();
    tmem[0] = 8'h1D; tmem[1] = 8'h2E; tmem[2] = 8'h74; tmem[3] = 8'hF0;
    tmem[4] = 8'hE0; tmem[5] = 8'h3F; tmem[6] = 8'h88; tmem[7] = 8'hF0;
    tmem[8] = 8'h7A; tmem[9] = 8'hF0; tmem[10] = 8'hE0; tmem[11] = 8'hF0;
    tmem[13] = 8'd200; tmem[14] = 8'd100; tmem[15] = 8'd44;
    run_prog(100, cyc);
    check("t2_first_out", first_out, 8'd44);
    check("t2_last_out", last_out, 8'd0);
    check("t2_pulses", n_valid, 2);
    check("t2_pc", o_pc, 4'd12);

    // LDA with three wait cycles on the data access
    clear_prog();
    tmem[0] = 8'h15; tmem[1] = 8'hF0; tmem[5] = 8'h77;
    wait_tab[1] = 3;
    run_prog(50, cyc);
    check("t3_halt_cycle", cyc, 9);
    check("t3_a", bus.wdata, 8'h77);

    // JZ/JNZ and PC wrap via NOP at address 15
    clear_prog();
    tmem[0] = 8'h86; tmem[1] = 8'h1D; tmem[2] = 8'h3D; tmem[3] = 8'h8F;
    tmem[4] = 8'hF0; tmem[5] = 8'hF0; tmem[6] = 8'h99; tmem[7] = 8'hE0;
    tmem[8] = 8'hF0; tmem[13] = 8'h05; tmem[15] = 8'h00;
    run_prog(100, cyc);
    check("t4_halt_cycle", cyc, 21);
    check("t4_pc", o_pc, 4'd9);
    check("t4_fetch0", n_fetch0, 2);
    check("t4_out", last_out, 8'd0);

    // Reset while a data access is pending
    clear_prog();
    tmem[0] = 8'h15; tmem[1] = 8'hF0; tmem[5] = 8'hAB;
    wait_tab[1] = 20;
    chk_en = 1'b0; i_rst = 1'b0; acc_idx = 0; cnt = 0;
    @(negedge i_clk);
    i_rst = 1'b1;
    for (int k = 0; k < 20 && !(acc_idx == 1 && bus.req); k++) @(negedge i_clk);
    repeat (2) @(negedge i_clk);
    check("t5_pending_req", bus.req, 1'b1);
    check("t5_pending_addr", bus.addr, 4'd5);
    i_rst = 1'b0;
    #1;
    check_reset_outputs("t5_rst");
    wait_tab[1] = 0;
    run_prog(50, cyc);
    check("t5_halt_cycle", cyc, 6);
    check("t5_a", bus.wdata, 8'hAB);

    // STA: implemented or NOP depending on build
    clear_prog();
    tmem[0] = 8'h59; tmem[1] = 8'h4C; tmem[2] = 8'h1C; tmem[3] = 8'hE0;
    tmem[4] = 8'hF0; tmem[12] = 8'h33;
    run_prog(60, cyc);
`ifdef CPU_CORE_STA_EN
    check("t6_out", last_out, 8'h09);
    check("t6_mem12", tmem[12], 8'h09);
    check("t6_we_cycles", n_we, 1);
    check("t6_halt_cycle", cyc, 13);
`else
    check("t6_out", last_out, 8'h33);
    check("t6_mem12", tmem[12], 8'h33);
    check("t6_we_cycles", n_we, 0);
    check("t6_halt_cycle", cyc, 12);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/cpu_core.md
CPU_CORE -- requirements
Module: cpu_core

Interface
REQ-001 Parameter DATA_W, default 8, data path and instruction word width; legal range 8..32.
REQ-002 Parameter ADDR_W, default 4, memory address and PC width; legal range 4..DATA_W-4.
REQ-003 i_clk  in  1  single clock; all state changes on its rising edge.
REQ-004 i_rst  in  1  reset; asynchronous and active-low.
REQ-005 o_mem_req  out  1  memory request, held until acknowledged.
REQ-006 o_mem_we  out  1  1 = write, 0 = read; valid while o_mem_req=1.
REQ-007 o_mem_addr  out  ADDR_W  memory address; stable while o_mem_req=1.
REQ-008 o_mem_wdata  out  DATA_W  write data, equal to register A.
REQ-009 i_mem_rdata  in  DATA_W  read data; sampled in the cycle in which i_mem_ack=1.
REQ-010 i_mem_ack  in  1  completes the pending request; ignored while o_mem_req=0.
REQ-011 o_out  out  DATA_W  output register.
REQ-012 o_out_valid  out  1  one-cycle pulse; high in the cycle after o_out updates.
REQ-013 o_halted  out  1  high while in HALT.
REQ-014 o_pc  out  ADDR_W  current program counter.

Function
REQ-015 Instruction format: opcode = IR[DATA_W-1:DATA_W-4]; operand = IR[ADDR_W-1:0]; immediate = IR[DATA_W-5:0], zero-extended.
REQ-016 Opcode map: 0000 NOP, 0001 LDA, 0010 ADD, 0011 SUB, 0100 STA, 0101 LDI, 0110 JMP, 0111 JC, 1000 JZ, 1001 JNZ, 1110 OUT, 1111 HLT. Any other opcode executes as NOP.
REQ-017 The block shall implement the states FETCH, DECODE, MEM and HALT, plus internal registers A, IR, PC, C and Z.
REQ-018 FETCH: o_mem_req=1, o_mem_we=0, o_mem_addr=PC. On ack: IR<=i_mem_rdata, PC<=PC+1 modulo 2^ADDR_W, next state DECODE.
REQ-019 DECODE takes one cycle and performs no memory access, then dispatches:
  - LDA/ADD/SUB/STA: go to MEM.
  - HLT: go to HALT.
  - All others: complete in DECODE and go to FETCH.
REQ-020 LDI: A<=immediate. JMP: PC<=operand. JC/JZ/JNZ: PC<=operand when C=1 / Z=1 / Z=0 respectively; otherwise PC is unchanged.
REQ-021 OUT: o_out<=A in DECODE; o_out_valid=1 for exactly the following cycle.
REQ-022 MEM: o_mem_req=1, o_mem_addr=operand; o_mem_we=1 only for STA. On ack:
  - LDA: A<=rdata.
  - ADD: A<=A+rdata.
  - SUB: A<=A-rdata.
  - STA: A is written to memory.
  - Next state: FETCH.
REQ-023 Arithmetic is modulo 2^DATA_W.
  - ADD: C = carry out of bit DATA_W-1.
  - SUB: C = 1 when A>=rdata (no borrow).
  - ADD/SUB: Z = 1 when the result is 0.
  - C and Z are written only by ADD/SUB.
REQ-024 Latency with zero-wait memory (ack in first request cycle): 2 cycles for register/jump ops, 3 cycles for LDA/ADD/SUB/STA. Each extra wait cycle adds 1.
REQ-025 o_mem_addr, o_mem_we and o_mem_wdata shall not change while o_mem_req=1 and ack has not yet been seen.
REQ-026 HALT: o_mem_req=0, o_halted=1; no register changes. Only reset exits HALT.
REQ-027 PC wrap: a fetch from address 2^ADDR_W-1 sets PC to 0.

Reset
REQ-028 While i_rst=0, asynchronously:
  - A, IR, PC, C, Z, o_out = 0.
  - o_out_valid, o_mem_req, o_mem_we, o_halted = 0.
  - State = FETCH.
REQ-029 Reset asserted mid-request drops o_mem_req in the same cycle; the pending ack is discarded.
REQ-030 After reset is released, the first request is a fetch from address 0 on the next rising edge.

Configuration
REQ-031 Macro CPU_CORE_STA_EN:
  - Defined: STA (0100) is implemented per REQ-022.
  - Undefined: 0100 executes as NOP (2 cycles), o_mem_we is tied to 0, and no write logic exists.

Verification
REQ-032 Reset, then program LDI 3; OUT; HLT, zero-wait -> o_out=3 with one o_out_valid pulse; o_halted=1 at cycle 7; o_mem_req stays 0 afterwards.
REQ-033 DATA_W=8, A=200, ADD from a memory word holding 100 -> A=44, C=1, Z=0; then SUB of 44 -> A=0, C=1, Z=1.
REQ-034 Hold i_mem_ack low for 3 cycles during LDA -> o_mem_addr and o_mem_req are stable throughout; A updates only after ack; total instruction time is 6 cycles.
REQ-035 JZ loop: SUB to zero, then JZ 0 -> PC=0; repeat with Z=0 -> PC advances. With ADDR_W=4 and a NOP at address 15 -> PC wraps to 0.
REQ-036 Assert reset while o_mem_req=1 during MEM -> all outputs are zero immediately; after release the fetch is from address 0. With CPU_CORE_STA_EN undefined, STA -> o_mem_we never asserts and memory is unchanged.
